// File: rtl/four_bit_adder_if.sv
// four_bit_adder_if: scalar operand, carry-in and result bits of a registered nibble adder
interface four_bit_adder_if;
  logic a0, a1, a2, a3;
  logic b0, b1, b2, b3;
  logic c0;
  logic r0, r1, r2, r3, r4;
  modport master (output a0, a1, a2, a3, b0, b1, b2, b3, c0, input r0, r1, r2, r3, r4);
  modport slave (input a0, a1, a2, a3, b0, b1, b2, b3, c0, output r0, r1, r2, r3, r4);
endinterface

// File: rtl/four_bit_adder.sv
// four_bit_adder: registered 4-bit ripple-carry adder; clk, rst_n (sync active-low), bus carries a0..a3, b0..b3, c0 in and r0..r4 out
module four_bit_adder (
  input logic clk,
  input logic rst_n,
  four_bit_adder_if.slave bus
);
  logic [3:0] a, b, s;
  logic [4:0] c, r;
  assign a = {bus.a3, bus.a2, bus.a1, bus.a0};
  assign b = {bus.b3, bus.b2, bus.b1, bus.b0};
  assign c[0] = bus.c0;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = a[i] & b[i] | a[i] & c[i] | b[i] & c[i];
  end
  always_ff @(posedge clk)
    r <= rst_n ? {c[4], s} : 5'd0;
  assign {bus.r4, bus.r3, bus.r2, bus.r1, bus.r0} = r;
endmodule

// File: tb/tb_four_bit_adder.sv
// tb_four_bit_adder: directed and exhaustive checks of the registered nibble adder
module tb_four_bit_adder;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  four_bit_adder_if bus ();
  four_bit_adder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic cv, input logic rv);
    {bus.a3, bus.a2, bus.a1, bus.a0} = av;
    {bus.b3, bus.b2, bus.b1, bus.b0} = bv;
    bus.c0 = cv;
    rst_n = rv;
  endtask
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.r4, bus.r3, bus.r2, bus.r1, bus.r0};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic cv, input logic rv,
                      input string tag, input logic [4:0] exp);
    drive(av, bv, cv, rv);
    @(posedge clk);
    @(negedge clk);
    check(tag, exp);
  endtask
  initial begin
    logic [8:0] v;
    logic rv;
    logic [4:0] exp;
    step(4'd15, 4'd15, 1'b1, 1'b0, "reset_1", 5'b00000);
    step(4'd15, 4'd15, 1'b1, 1'b0, "reset_2", 5'b00000);
    step(4'd15, 4'd15, 1'b1, 1'b1, "release_31", 5'b11111);
    step(4'd2, 4'd2, 1'b0, 1'b1, "2+2", 5'b00100);
    step(4'd1, 4'd2, 1'b0, 1'b1, "1+2", 5'b00011);
    step(4'd1, 4'd2, 1'b0, 1'b1, "1+2_hold", 5'b00011);
    drive(4'd9, 4'd9, 1'b1, 1'b1);
    #2;
    check("hold_until_edge", 5'b00011);
    step(4'd2, 4'd14, 1'b1, 1'b1, "2+14+1", 5'b10001);
    step(4'd15, 4'd0, 1'b1, 1'b1, "ripple_16", 5'b10000);
    step(4'd0, 4'd0, 1'b0, 1'b1, "zero", 5'b00000);
    step(4'd7, 4'd8, 1'b0, 1'b1, "7+8", 5'b01111);
    step(4'd7, 4'd8, 1'b1, 1'b0, "mid_reset", 5'b00000);
    step(4'd5, 4'd6, 1'b0, 1'b1, "after_reset", 5'b01011);
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      rv = ($urandom_range(0, 15) != 0);
      exp = rv ? 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]) : 5'd0;
      step(v[7:4], v[3:0], v[8], rv, "exhaustive", exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
